// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bin_to_bcd_pkg;

  localparam int unsigned BIN_W_DEFAULT      = 16;
  localparam int unsigned BCD_DIGITS_DEFAULT = 5;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] digit_adj_c
);

  always_comb begin
    digit_adj_c = digit;
    if (digit >= ADJ_THRESH) digit_adj_c = digit + ADJ_ADD;
  end

endmodule

// File: rtl/bin_to_bcd_16.sv
// Sequential double-dabble converter, 16-bit binary to 5-digit packed BCD.
// Define BIN_TO_BCD_EARLY_EXIT_EN to skip leading zero bits at accept.
module bin_to_bcd_16
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = BIN_W_DEFAULT,
  parameter int unsigned BCD_DIGITS = BCD_DIGITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic [BIN_W-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    done,
  output logic                    busy
);

  localparam int unsigned SCR_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = 5;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [BIN_W-1:0]   shf_q, shf_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [BIN_W-1:0]   load_shf;
  logic [CNT_W-1:0]   load_cnt;
  logic               last_iter;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit       (scr_q[4*g +: 4]),
      .digit_adj_c (scr_adj[4*g +: 4])
    );
  end

`ifdef BIN_TO_BCD_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz;

  // Leading-zero count; the highest set bit wins.
  always_comb begin
    lz = CNT_W'(BIN_W);
    for (int i = 0; i < BIN_W; i++) begin
      if (bin[i]) lz = CNT_W'(BIN_W - 1 - i);
    end
  end

  // A zero input still runs one iteration so done is always produced.
  always_comb begin
    load_shf = bin << lz;
    load_cnt = (lz == CNT_W'(BIN_W)) ? CNT_W'(1) : CNT_W'(BIN_W) - lz;
  end
`else
  always_comb begin
    load_shf = bin;
    load_cnt = CNT_W'(BIN_W);
  end
`endif

  assign last_iter = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (init)      state_d = ST_CONVERT;
      ST_CONVERT: if (last_iter) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    scr_d  = scr_q;
    shf_d  = shf_q;
    bcd_d  = bcd_q;
    done_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          scr_d  = '0;
          shf_d  = load_shf;
          cnt_d  = load_cnt;
          busy_d = 1'b1;
        end
      end
      ST_CONVERT: begin
        {scr_d, shf_d} = {scr_adj, shf_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (last_iter) begin
          bcd_d  = scr_d;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      scr_q  <= '0;
      shf_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      scr_q  <= scr_d;
      shf_q  <= shf_d;
      bcd_q  <= bcd_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule
